// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// General-purpose integer register file for the RV32I datapath (x0..x31 by
// default). Two combinational read ports feed the rs1/rs2 operands to the
// ALU, and one synchronous write port takes rd writeback. Register 0 is
// hardwired to zero: writes to it are dropped and reads of it return zero.
//
// Parameters:
//   REG_WIDTH  bit width of each register and of the data ports
//   REG_DEPTH  number of registers (power of two, >= 2)
//
// Ports:
//   i_Clk    in   1          clock, all state changes on the rising edge
//   i_Rst    in   1          synchronous active-high reset, clears all regs
//   i_Addr1  in   AW         read address, port 1 (rs1)
//   i_Addr2  in   AW         read address, port 2 (rs2)
//   i_Addr3  in   AW         write address, port 3 (rd)
//   o_RD1    out  REG_WIDTH  read data for i_Addr1
//   o_RD2    out  REG_WIDTH  read data for i_Addr2
//   i_WE3    in   1          write enable for port 3
//   i_WD3    in   REG_WIDTH  write data for port 3
// ---------------------------------------------------------------------------
module register_file #(
  parameter int REG_WIDTH = 32,
  parameter int REG_DEPTH = 32,
  parameter int AW        = $clog2(REG_DEPTH)
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic [AW-1:0]        i_Addr1,
  input  logic [AW-1:0]        i_Addr2,
  input  logic [AW-1:0]        i_Addr3,
  output logic [REG_WIDTH-1:0] o_RD1,
  output logic [REG_WIDTH-1:0] o_RD2,
  input  logic                 i_WE3,
  input  logic [REG_WIDTH-1:0] i_WD3
);

  logic [REG_WIDTH-1:0] reg_mem [REG_DEPTH];
  logic                 write_hit;

  // A write only lands when enabled and aimed at a real register; address 0
  // is filtered here so entry 0 of the storage never leaves its reset value.
  assign write_hit = i_WE3 && (i_Addr3 != '0);

  // Storage update. Reset wins over a write on the same edge, so a write
  // issued alongside reset is lost and every entry comes out as zero.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      for (int i = 0; i < REG_DEPTH; i++) begin
        reg_mem[i] <= '0;
      end
    end else if (write_hit) begin
      reg_mem[i_Addr3] <= i_WD3;
    end
  end

  // Read ports are purely combinational with no write bypass: a read of the
  // register being written shows the old value until the edge. Address 0 is
  // forced to zero so it reads cleanly even before the first reset.
  assign o_RD1 = (i_Addr1 == '0) ? '0 : reg_mem[i_Addr1];
  assign o_RD2 = (i_Addr2 == '0) ? '0 : reg_mem[i_Addr2];

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Scoreboard bench for register_file. Each stimulus step drives the ports,
// pushes the read data a plain array model predicts into a queue, and a
// monitor on the falling edge pops and compares against o_RD1/o_RD2.
// ---------------------------------------------------------------------------
module tb_register_file;

  localparam int W  = 32;
  localparam int D  = 32;
  localparam int AW = 5;

  typedef struct {
    string        tag;
    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
  } exp_t;

  logic          i_Clk;
  logic          i_Rst;
  logic [AW-1:0] i_Addr1;
  logic [AW-1:0] i_Addr2;
  logic [AW-1:0] i_Addr3;
  logic [W-1:0]  o_RD1;
  logic [W-1:0]  o_RD2;
  logic          i_WE3;
  logic [W-1:0]  i_WD3;

  exp_t          exp_q[$];
  logic [W-1:0]  model[D];
  int            total = 0;
  int            bad   = 0;

  register_file #(
    .REG_WIDTH(W),
    .REG_DEPTH(D)
  ) dut (
    .i_Clk  (i_Clk),
    .i_Rst  (i_Rst),
    .i_Addr1(i_Addr1),
    .i_Addr2(i_Addr2),
    .i_Addr3(i_Addr3),
    .o_RD1  (o_RD1),
    .o_RD2  (o_RD2),
    .i_WE3  (i_WE3),
    .i_WD3  (i_WD3)
  );

  // Free-running clock, period 10.
  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Reference read: register 0 is zero, everything else is the array entry.
  function automatic logic [W-1:0] modelRead(input int addr);
    return (addr == 0) ? '0 : model[addr];
  endfunction

  // Monitor: whenever the falling edge arrives, drain every pending
  // expectation and compare it with what the read ports show right now.
  always @(negedge i_Clk) begin
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      total++;
      if (o_RD1 !== e.exp1) begin
        bad++;
        $display("[TB] FAIL %s rd1 got %h want %h", e.tag, o_RD1, e.exp1);
      end
      total++;
      if (o_RD2 !== e.exp2) begin
        bad++;
        $display("[TB] FAIL %s rd2 got %h want %h", e.tag, o_RD2, e.exp2);
      end
    end
  end

  // One clock step: drive just after a rising edge, queue the pre-edge read
  // expectation (the model still holds old contents, so no bypass is
  // assumed), then let the next rising edge commit into the model.
  task automatic applyStimulus(input logic rst, input logic we,
                               input int a1, input int a2, input int a3,
                               input logic [W-1:0] wd, input bit check,
                               input string tag);
    exp_t e;
    @(posedge i_Clk);
    #1;
    i_Rst   = rst;
    i_WE3   = we;
    i_Addr1 = a1[AW-1:0];
    i_Addr2 = a2[AW-1:0];
    i_Addr3 = a3[AW-1:0];
    i_WD3   = wd;
    if (check) begin
      e.tag  = tag;
      e.exp1 = modelRead(a1);
      e.exp2 = modelRead(a2);
      exp_q.push_back(e);
    end
    @(posedge i_Clk);
    if (rst) begin
      for (int i = 0; i < D; i++) model[i] = '0;
    end else if (we && a3 != 0) begin
      model[a3] = wd;
    end
  endtask

  // Read-only step used to observe state after a write edge.
  task automatic checkOutput(input int a1, input int a2, input string tag);
    applyStimulus(1'b0, 1'b0, a1, a2, 0, '0, 1'b1, tag);
  endtask

  initial begin
    i_Rst = 1'b0; i_WE3 = 1'b0; i_Addr1 = '0; i_Addr2 = '0;
    i_Addr3 = '0; i_WD3 = '0;

    // Reset for two edges, then sweep every address on both ports.
    applyStimulus(1'b1, 1'b0, 0, 0, 0, '0, 1'b0, "rst");
    applyStimulus(1'b1, 1'b0, 0, 0, 0, '0, 1'b0, "rst");
    for (int a = 0; a < D; a++) checkOutput(a, D - 1 - a, "reset_sweep");

    // Basic write with both ports on x2: old value before the edge.
    applyStimulus(1'b0, 1'b1, 2, 2, 2, 32'hAAAAAAAA, 1'b1, "wr_x2_nobypass");
    checkOutput(2, 2, "wr_x2_after");

    // Write enable low must not change x2.
    applyStimulus(1'b0, 1'b0, 2, 2, 2, 32'h55555555, 1'b1, "we0_before");
    checkOutput(2, 2, "we0_after");

    // Top register.
    applyStimulus(1'b0, 1'b1, 31, 2, 31, 32'hFFFFFFFF, 1'b1, "wr_x31_before");
    checkOutput(31, 2, "wr_x31_after");

    // x0 write is discarded.
    applyStimulus(1'b0, 1'b1, 0, 0, 0, 32'hFFFFFFFF, 1'b1, "x0_before");
    checkOutput(0, 0, "x0_after");
    checkOutput(2, 31, "x0_others");

    // Reset alongside a write: everything ends at zero, write lost.
    applyStimulus(1'b1, 1'b1, 2, 5, 5, 32'h12345678, 1'b1, "rstpri_before");
    checkOutput(2, 5, "rstpri_x2_x5");
    checkOutput(31, 0, "rstpri_x31");

    // First write after reset takes effect on the first released edge.
    applyStimulus(1'b0, 1'b1, 5, 5, 5, 32'h12345678, 1'b1, "post_rst_wr");
    checkOutput(5, 2, "post_rst_after");

    // Randomized traffic, with an occasional reset mixed in.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(0, 39) == 0),
                    ($urandom_range(0, 3) != 0),
                    int'($urandom_range(0, D - 1)),
                    int'($urandom_range(0, D - 1)),
                    int'($urandom_range(0, D - 1)),
                    $urandom, 1'b1, "random");
    end

    // Final full sweep compares every register against the model.
    for (int a = 0; a < D; a++) checkOutput(a, (a + 7) % D, "final_sweep");

    @(posedge i_Clk);
    @(negedge i_Clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("[TB] FAIL drain pending got %0d want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
